// File: rtl/vec_mem_seq_if.sv
// Bus bundles for vec_mem_seq: the vector request/response side and the 8-bank memory side.
interface vec_mem_seq_req_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_rw;
    logic [8:0]   req_base;
    logic [3:0]   req_len;
    logic [8:0]   req_stride;
    logic [255:0] wdata;
    logic [255:0] rdata;
    logic         resp_valid;
    logic         busy;

    modport master (
        output req_valid, req_rw, req_base, req_len, req_stride, wdata,
        input  req_ready, rdata, resp_valid, busy
    );

    modport slave (
        input  req_valid, req_rw, req_base, req_len, req_stride, wdata,
        output req_ready, rdata, resp_valid, busy
    );
endinterface

interface vec_mem_seq_mem_if;
    logic [31:0] mem_din;
    logic [5:0]  mem_addr;
    logic [2:0]  mem_bank_select;
    logic        mem_rw;
    logic        mem_start;
    logic        mem_ready;
    logic        mem_done;
    logic [31:0] mem_dout;

    modport master (
        output mem_din, mem_addr, mem_bank_select, mem_rw, mem_start,
        input  mem_ready, mem_done, mem_dout
    );

    modport slave (
        input  mem_din, mem_addr, mem_bank_select, mem_rw, mem_start,
        output mem_ready, mem_done, mem_dout
    );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: walks up to 8 elements over an 8-bank memory, one access at a time.
// Optional feature: define VMS_STRIDE_EN to step the element address by req_stride instead of 1.
module vec_mem_seq (
    input  logic               clk,
    input  logic               reset,
    vec_mem_seq_req_if.slave   req,
    vec_mem_seq_mem_if.master  mem
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t       state;
    state_t       next_state;
    logic [3:0]   idx;
    logic [3:0]   len_q;
    logic         rw_q;
    logic [8:0]   cur_addr;
    logic [8:0]   step;
    logic [255:0] wdata_q;
    logic [255:0] rdata_q;
    logic         resp_q;
    logic [3:0]   len_clamped;
    logic         accept;
    logic         elem_done;
    logic         last_elem;

    assign len_clamped = (req.req_len > 4'd8) ? 4'd8 : req.req_len;
    assign accept      = (state == IDLE) && req.req_valid;
    assign elem_done   = (state == WAIT) && mem.mem_done;
    assign last_elem   = (idx + 4'd1) == len_q;

`ifdef VMS_STRIDE_EN
    logic [8:0] stride_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stride_q <= '0;
        end else if (accept) begin
            stride_q <= req.req_stride;
        end
    end

    assign step = stride_q;
`else
    logic unused_stride;

    assign unused_stride = ^req.req_stride;
    assign step          = 9'd1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req.req_valid) begin
                    next_state = (len_clamped == 4'd0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem.mem_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_done) begin
                    next_state = last_elem ? RESP : ISSUE;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory-side address/data come straight from held registers, so they stay put across ISSUE and WAIT.
    always_comb begin
        req.req_ready       = (state == IDLE);
        req.busy            = (state != IDLE);
        req.rdata           = rdata_q;
        req.resp_valid      = resp_q;
        mem.mem_start       = (state == ISSUE) && mem.mem_ready;
        mem.mem_bank_select = cur_addr[2:0];
        mem.mem_addr        = cur_addr[8:3];
        mem.mem_din         = wdata_q[{idx[2:0], 5'd0} +: 32];
        mem.mem_rw          = rw_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            len_q    <= '0;
            rw_q     <= 1'b0;
            cur_addr <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
        end else begin
            resp_q <= (state == RESP);
            if (accept) begin
                rw_q     <= req.req_rw;
                len_q    <= len_clamped;
                cur_addr <= req.req_base;
                wdata_q  <= req.wdata;
                idx      <= '0;
            end else if (elem_done) begin
                if (!rw_q) begin
                    rdata_q[{idx[2:0], 5'd0} +: 32] <= mem.mem_dout;
                end
                idx      <= idx + 4'd1;
                cur_addr <= cur_addr + step;
            end
        end
    end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Randomized self-checking bench for vec_mem_seq against an 8-bank memory model and a
// list-of-accesses reference computed from base/len/step.
`timescale 1ns/1ps
module tb_vec_mem_seq;

    typedef struct packed {
        logic [2:0]  bank;
        logic [5:0]  addr;
        logic        rw;
        logic [31:0] din;
    } acc_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vec_mem_seq_req_if req_if();
    vec_mem_seq_mem_if mem_if();

    vec_mem_seq dut (
        .clk   (clk),
        .reset (reset),
        .req   (req_if),
        .mem   (mem_if)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           overlap_cnt = 0;
    int           resp_cnt = 0;
    bit           outstanding = 1'b0;
    acc_t         log_q[$];
    acc_t         exp_q[$];
    logic [31:0]  mem_arr [512];
    logic [31:0]  gold [512];
    logic [255:0] rdata_exp = '0;
    int           exp_n;
    logic         exp_rw;
    int           exp_addr [8];
    logic [255:0] exp_wd;
    int           mem_lat = 1;
    bit           ready_auto = 1'b1;
    bit           stall_en = 1'b0;
    logic         ready_force = 1'b1;
    bit           inject_done = 1'b0;
    bit           pending;
    int           lat_cnt;

    always @(posedge clk) cyc++;

    // Memory model: captures each start, answers with a done pulse mem_lat cycles later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_if.mem_done <= 1'b0;
            pending         <= 1'b0;
            lat_cnt         <= 0;
        end else begin
            mem_if.mem_done <= inject_done;
            if (pending) begin
                if (lat_cnt == 0) begin
                    mem_if.mem_done <= 1'b1;
                    pending         <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
            if (mem_if.mem_start) begin
                acc_t e;
                e.bank = mem_if.mem_bank_select;
                e.addr = mem_if.mem_addr;
                e.rw   = mem_if.mem_rw;
                e.din  = mem_if.mem_din;
                log_q.push_back(e);
                if (mem_if.mem_rw) begin
                    mem_arr[{mem_if.mem_addr, mem_if.mem_bank_select}] = mem_if.mem_din;
                end else begin
                    mem_if.mem_dout <= mem_arr[{mem_if.mem_addr, mem_if.mem_bank_select}];
                end
                if (mem_lat <= 1) begin
                    mem_if.mem_done <= 1'b1;
                end else begin
                    pending <= 1'b1;
                    lat_cnt <= mem_lat - 2;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            if (mem_if.mem_done) outstanding = 1'b0;
            if (mem_if.mem_start) begin
                if (outstanding) overlap_cnt++;
                outstanding = 1'b1;
            end
            if (req_if.resp_valid) resp_cnt++;
        end else begin
            outstanding = 1'b0;
        end
    end

    initial begin
        mem_if.mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mem_if.mem_ready = ready_auto ? (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1) : ready_force;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Builds the expected access list, then presents the request and waits for it to be taken.
    task automatic applyStimulus(input logic rw, input logic [8:0] base, input logic [3:0] len,
                                 input logic [8:0] stride, input logic [255:0] wd, input bit garbage);
        int n;
        int step;
        int a;
        bit ready_seen;
        acc_t e;
        n = (len > 4'd8) ? 8 : int'(len);
`ifdef VMS_STRIDE_EN
        step = int'(stride);
`else
        step = 1;
`endif
        exp_q.delete();
        log_q.delete();
        exp_n  = n;
        exp_rw = rw;
        exp_wd = wd;
        for (int i = 0; i < n; i++) begin
            a = (int'(base) + i * step) % 512;
            exp_addr[i] = a;
            e.bank = a[2:0];
            e.addr = a[8:3];
            e.rw   = rw;
            e.din  = wd[32*i +: 32];
            exp_q.push_back(e);
        end
        ready_seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_if.req_ready) begin
                ready_seen = 1'b1;
                break;
            end
        end
        checkOutput("req_ready_idle", ready_seen, 1'b1);
        req_if.req_valid  = 1'b1;
        req_if.req_rw     = rw;
        req_if.req_base   = base;
        req_if.req_len    = len;
        req_if.req_stride = stride;
        req_if.wdata      = wd;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (garbage) begin
            req_if.req_rw     = ~rw;
            req_if.req_base   = 9'($urandom);
            req_if.req_len    = 4'($urandom);
            req_if.req_stride = 9'($urandom);
            for (int i = 0; i < 8; i++) req_if.wdata[32*i +: 32] = $urandom;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
        end
        req_if.req_valid = 1'b0;
    endtask

    task automatic waitResponse(input bit check_lat);
        bit got;
        int lat;
        int nchk;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (req_if.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("resp_seen", got, 1'b1);
        lat = cyc - acc_cyc + 1;
        if (check_lat) checkOutput("latency", lat, 2 * exp_n + 2);
        checkOutput("access_count", log_q.size(), exp_q.size());
        nchk = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++) begin
            checkOutput($sformatf("access%0d", i), log_q[i], exp_q[i]);
        end
        for (int i = 0; i < exp_n; i++) begin
            if (exp_rw) gold[exp_addr[i]] = exp_wd[32*i +: 32];
            else        rdata_exp[32*i +: 32] = gold[exp_addr[i]];
        end
        checkOutput("rdata", req_if.rdata, rdata_exp);
        checkOutput("overlap", overlap_cnt, 0);
        @(negedge clk);
        checkOutput("resp_one_cycle", req_if.resp_valid, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, req_if.busy, 1'b0);
        checkOutput({tag, "_resp"}, req_if.resp_valid, 1'b0);
        checkOutput({tag, "_start"}, mem_if.mem_start, 1'b0);
        checkOutput({tag, "_rdata"}, req_if.rdata, '0);
        checkOutput({tag, "_addr"}, mem_if.mem_addr, '0);
        checkOutput({tag, "_bank"}, mem_if.mem_bank_select, '0);
        checkOutput({tag, "_din"}, mem_if.mem_din, '0);
        checkOutput({tag, "_rw"}, mem_if.mem_rw, 1'b0);
    endtask

    initial begin
        logic [255:0] wd;
        logic [255:0] wd34;
        logic [31:0]  v;
        logic         rw;
        logic [3:0]   len;
        logic [8:0]   stride;
        int           seen;
        int           resp0;
        bit           fixed;

        req_if.req_valid  = 1'b0;
        req_if.req_rw     = 1'b0;
        req_if.req_base   = '0;
        req_if.req_len    = '0;
        req_if.req_stride = '0;
        req_if.wdata      = '0;
        for (int i = 0; i < 512; i++) begin
            v = $urandom;
            mem_arr[i] = v;
            gold[i]    = v;
        end

        #1 reset = 1'b0;
        #2;
        checkResetOutputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("por_req_ready", req_if.req_ready, 1'b1);

        $display("[TB] unit-stride read from base 0x005");
        for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom;
        applyStimulus(1'b0, 9'h005, 4'd4, 9'd1, wd, 1'b1);
        waitResponse(1'b1);
        checkOutput("read4_words", req_if.rdata[127:0], {gold[8], gold[7], gold[6], gold[5]});

        $display("[TB] wrapping write and read-back");
        for (int i = 0; i < 8; i++) wd34[32*i +: 32] = 32'h11 * (i + 1);
        applyStimulus(1'b1, 9'h1FC, 4'd8, 9'd1, wd34, 1'b1);
        waitResponse(1'b1);
        for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom;
        applyStimulus(1'b0, 9'h1FC, 4'd8, 9'd1, wd, 1'b1);
        waitResponse(1'b1);
        checkOutput("readback", req_if.rdata, wd34);

        $display("[TB] ready stall with a stray done");
        ready_auto  = 1'b0;
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 9'h0A2, 4'd2, 9'd1, wd, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput("stall_start", mem_if.mem_start, 1'b0);
            checkOutput("stall_bank", mem_if.mem_bank_select, 3'd2);
            checkOutput("stall_addr", mem_if.mem_addr, 6'h14);
            if (k == 1) inject_done = 1'b1;
            if (k == 2) inject_done = 1'b0;
        end
        ready_force = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_start", mem_if.mem_start, 1'b1);
        ready_auto = 1'b1;
        waitResponse(1'b0);

        $display("[TB] stray done while idle, len 0 and len 12");
        @(negedge clk);
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_done_busy", req_if.busy, 1'b0);
        checkOutput("idle_done_rdata", req_if.rdata, rdata_exp);
        applyStimulus(1'b0, 9'h123, 4'd0, 9'd1, wd, 1'b0);
        waitResponse(1'b1);
        applyStimulus(1'b1, 9'h040, 4'd12, 9'd1, wd, 1'b1);
        waitResponse(1'b1);
        checkOutput("len12_starts", log_q.size(), 8);

`ifdef VMS_STRIDE_EN
        $display("[TB] stride 8 stays in one bank");
        applyStimulus(1'b0, 9'd3, 4'd3, 9'd8, wd, 1'b1);
        waitResponse(1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i < log_q.size()) begin
                checkOutput($sformatf("stride_bank%0d", i), log_q[i].bank, 3'd3);
                checkOutput($sformatf("stride_addr%0d", i), log_q[i].addr, 6'(i));
            end
        end
`endif

        $display("[TB] reset after second element");
        applyStimulus(1'b0, 9'h0F0, 4'd6, 9'd1, wd, 1'b0);
        seen = 0;
        for (int k = 0; k < 100 && seen < 2; k++) begin
            @(negedge clk);
            if (mem_if.mem_done) seen++;
        end
        checkOutput("abort_two_done", seen, 2);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkResetOutputs("abort");
        rdata_exp = '0;
        resp0 = resp_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("abort_no_resp", resp_cnt - resp0, 0);
        checkOutput("abort_starts", log_q.size(), 2);
        checkOutput("abort_ready", req_if.req_ready, 1'b1);
        applyStimulus(1'b0, 9'h0F0, 4'd6, 9'd1, wd, 1'b1);
        waitResponse(1'b1);

        $display("[TB] randomized requests");
        for (int t = 0; t < 40; t++) begin
            rw  = 1'($urandom_range(0, 1));
            len = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       stride = 9'd0;
                1:       stride = 9'd8;
                default: stride = 9'($urandom);
            endcase
            for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom;
            stall_en = 1'($urandom_range(0, 1));
            mem_lat  = $urandom_range(1, 3);
            fixed    = !stall_en && (mem_lat == 1);
            repeat (2) @(negedge clk);
            applyStimulus(rw, 9'($urandom), len, stride, wd, len != 4'd0);
            waitResponse(fixed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
